// File: rtl/rom_stream_reader.sv
// Streams LEN consecutive words from a 1-cycle-latency synchronous ROM onto a valid/ready port.
// Define ROM_STREAM_READER_LAST_EN to add o_last, flagging the final beat of each transfer.
module rom_stream_reader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LEN_WIDTH     = ADDRESS_WIDTH + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_base,
    input  logic [LEN_WIDTH-1:0]     i_len,
    output logic [ADDRESS_WIDTH-1:0] o_rom_address,
    input  logic [DATA_WIDTH-1:0]    i_rom_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_busy,
    output logic                     o_done
`ifdef ROM_STREAM_READER_LAST_EN
    ,
    output logic                     o_last
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [LEN_WIDTH-1:0]     issue_rem_q, issue_rem_d;
    logic [LEN_WIDTH-1:0]     deliver_rem_q, deliver_rem_d;
    logic                     inflight_q, inflight_d;
    logic                     done_q, done_d;
    logic [DATA_WIDTH-1:0]    fifo_q [2];
    logic [DATA_WIDTH-1:0]    fifo_d [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;
`ifdef ROM_STREAM_READER_LAST_EN
    logic                     inflight_last_q, inflight_last_d;
    logic                     fifo_last_q [2];
    logic                     fifo_last_d [2];
`endif

    logic       pop, push, issue, start_acc, final_pop;
    logic [2:0] occ;

    // Stream handshake: a beat moves on a posedge where o_valid & i_ready; o_valid never
    // depends on i_ready, and o_data is held while o_valid=1 and i_ready=0.
    always_comb begin
        pop       = (count_q != 2'd0) && i_ready;
        push      = inflight_q;
        occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == S_RUN) && (issue_rem_q != '0) && (occ < 3'd2);
        start_acc = (state_q == S_IDLE) && i_start;
        final_pop = (state_q == S_FLUSH) && pop && (deliver_rem_q == LEN_WIDTH'(1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc && (i_len != '0)) state_d = S_RUN;
            S_RUN:   if (issue && (issue_rem_q == LEN_WIDTH'(1))) state_d = S_FLUSH;
            S_FLUSH: if (final_pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (state_q != S_IDLE);
        o_done        = done_q;
        o_valid       = (count_q != 2'd0);
        o_data        = fifo_q[rd_ptr_q];
        o_rom_address = issue ? addr_q : rom_addr_q;
`ifdef ROM_STREAM_READER_LAST_EN
        o_last        = o_valid && fifo_last_q[rd_ptr_q];
`endif
    end

    always_comb begin
        addr_d        = addr_q;
        rom_addr_d    = rom_addr_q;
        issue_rem_d   = issue_rem_q;
        deliver_rem_d = deliver_rem_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        inflight_d    = issue;
        done_d        = (start_acc && (i_len == '0)) || final_pop;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};
`ifdef ROM_STREAM_READER_LAST_EN
        fifo_last_d     = fifo_last_q;
        inflight_last_d = issue && (issue_rem_q == LEN_WIDTH'(1));
`endif
        if (start_acc) begin
            addr_d        = i_base;
            issue_rem_d   = i_len;
            deliver_rem_d = i_len;
        end
        if (issue) begin
            rom_addr_d  = addr_q;
            addr_d      = addr_q + ADDRESS_WIDTH'(1);
            issue_rem_d = issue_rem_q - LEN_WIDTH'(1);
        end
        if (pop) begin
            deliver_rem_d = deliver_rem_q - LEN_WIDTH'(1);
            rd_ptr_d      = ~rd_ptr_q;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = i_rom_data;
            wr_ptr_d         = ~wr_ptr_q;
`ifdef ROM_STREAM_READER_LAST_EN
            fifo_last_d[wr_ptr_q] = inflight_last_q;
`endif
        end
    end

    // Reset drops any in-flight ROM word by clearing inflight, so the next returned word is never pushed.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            addr_q        <= '0;
            rom_addr_q    <= '0;
            issue_rem_q   <= '0;
            deliver_rem_q <= '0;
            inflight_q    <= 1'b0;
            done_q        <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
`ifdef ROM_STREAM_READER_LAST_EN
            inflight_last_q <= 1'b0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
`endif
        end else begin
            addr_q        <= addr_d;
            rom_addr_q    <= rom_addr_d;
            issue_rem_q   <= issue_rem_d;
            deliver_rem_q <= deliver_rem_d;
            inflight_q    <= inflight_d;
            done_q        <= done_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
`ifdef ROM_STREAM_READER_LAST_EN
            inflight_last_q <= inflight_last_d;
            fifo_last_q     <= fifo_last_d;
`endif
        end
    end

endmodule
